dnn_result_unit: RTL and testbench
==================================

Name: dnn_result_unit

Overview:
Parametrised successor to the fixed 10-output inference top-level readout. It snapshots the class scores of an inference engine when the engine reports done. It then scans them sequentially to find the winning class and presents the result over a valid/ready handshake. A registered random-access port lets any snapshotted score be read back. It sits between the dnn_* engine core and the board/testbench interface.

Parameters:
DATA_WIDTH, 12, signed fixed-point score width
NUM_CLASSES, 10, number of engine outputs (>=1)
IDX_WIDTH, $clog2(NUM_CLASSES) min 1, width of class indices

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
clear  in  1  synchronous soft clear, active-high; same effect as rst
eng_done  in  1  engine done level
eng_out  in  NUM_CLASSES*DATA_WIDTH  signed scores; class i at bits [i*DATA_WIDTH +: DATA_WIDTH]
busy  out  1  high in SCAN or HOLD
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_class  out  IDX_WIDTH  argmax class index
res_score  out  DATA_WIDTH  score of res_class
overrun  out  1  sticky: eng_done rose while busy
rd_idx  in  4 (IDX_WIDTH if >4)  random-access read index
rd_data  out  DATA_WIDTH  registered score at rd_idx

Behaviour:
- Reset (rst==0 or clear==1 at clk edge): state IDLE; snapshot bank, best index/score, scan counter, rd_data, res_class, res_score = 0; res_valid, busy, overrun = 0; done_d = 0. Reset mid-SCAN/HOLD aborts the operation silently and drops any pending result.
- done_d registers eng_done each cycle. A rising edge is eng_done & ~done_d.
- IDLE: on a rising edge, capture all NUM_CLASSES scores into the bank in the same edge. Initialise best_idx=0, best=eng_out[0], cnt=1. Go to SCAN; if NUM_CLASSES==1, go directly to HOLD.
- SCAN: each cycle compare bank[cnt] > best (signed, strict); if true, best<=bank[cnt] and best_idx<=cnt. cnt increments. After cnt==NUM_CLASSES-1 is processed, go to HOLD. Ties resolve to the lowest index.
- HOLD: res_valid=1, res_class=best_idx, res_score=best, all held stable until res_valid&res_ready. On that handshake edge go to IDLE and deassert res_valid the next cycle.
- Latency: capture at edge T; res_valid high from edge T+NUM_CLASSES-1 onward, i.e. 9 cycles after capture for the default (10 SCAN-less cycles total incl. capture). res_ready may be high before res_valid; the handshake completes on the first cycle both are high.
- A rising edge of eng_done while busy: ignored, bank unchanged, overrun<=1. overrun is cleared only by rst/clear.
- Rising edge in the same cycle as the HOLD handshake: treated as busy, so it sets overrun and is not captured.
- eng_done held high continuously: only one capture occurs (edge-detected).
- Read port: rd_data<=bank[rd_idx] every cycle (1-cycle latency), valid in any state. rd_idx>=NUM_CLASSES returns bank[0]. The bank changes only at capture.
- No arithmetic widening: comparison only, and scores pass through bit-exact.

Optional Feature:
Macro DNN_RESULT_TOP2_EN. When defined, SCAN also tracks the runner-up. Extra ports: res_class2 (IDX_WIDTH), res_margin (DATA_WIDTH+1, signed, = best - second, computed at HOLD entry and registered). A value that displaces best moves the old best to second. A value that is > second but not > best replaces second. Ties are kept at the lower index. With NUM_CLASSES==1: res_class2=0, res_margin=0. When undefined: no extra ports or registers, and latency is identical.

Decomposition:
- Package dnn_result_pkg: state enum typedef (IDLE, SCAN, HOLD) as 2-bit logic; function idx_width(n) returning max(1,$clog2(n)); default DATA_WIDTH/NUM_CLASSES localparams shared with the engine top.
- Sub-module dnn_argmax_scan: holds cnt, best, best_idx (and runner-up under the macro). Inputs are start/init value and a bank element stream; it outputs last and the results. The bank, edge detect, FSM, handshake, and read port stay in dnn_result_unit.

Test Plan:
- Scores {3,-5,100,7,100,0,-2048,12,99,1}, pulse eng_done → res_valid at the stated cycle; res_class=2, res_score=100 (tie at 2 and 4 resolves to 2).
- All scores -2048 → res_class=0, res_score=-2048; with DNN_RESULT_TOP2_EN, res_class2=1, res_margin=0.
- res_ready low for 20 cycles after res_valid → outputs stable; raise res_ready → res_valid drops the next cycle, busy=0.
- Second eng_done edge mid-SCAN with new scores → result reflects the first snapshot, overrun=1; clear=1 → overrun=0, state IDLE.
- rd_idx sweep 0..15 after capture → rd_data equals the bank for indices 0..9 one cycle later, and bank[0] for 10..15.
- rst=0 asserted in HOLD → next cycle res_valid=0, rd_data=0, busy=0; a new eng_done edge is captured normally.

Source files
------------

// File: rtl/dnn_result_pkg.sv
// rtl/dnn_result_pkg.sv - shared types, defaults and helpers for the dnn result readout
package dnn_result_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DNN_DATA_WIDTH  = 12;
  localparam int DNN_NUM_CLASSES = 10;

  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dnn_argmax_scan.sv
// rtl/dnn_argmax_scan.sv - sequential argmax over a streamed score bank
// Optional runner-up tracking under DNN_RESULT_TOP2_EN.
module dnn_argmax_scan
  import dnn_result_pkg::*;
#(
  parameter int DATA_WIDTH  = DNN_DATA_WIDTH,
  parameter int NUM_CLASSES = DNN_NUM_CLASSES,
  parameter int IDX_WIDTH   = idx_width(NUM_CLASSES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         start,
  input  logic                         step,
  input  logic signed [DATA_WIDTH-1:0] init_val,
  input  logic signed [DATA_WIDTH-1:0] elem,
  output logic        [IDX_WIDTH-1:0]  cnt,
  output logic                         last,
  output logic signed [DATA_WIDTH-1:0] nxt_best,
  output logic        [IDX_WIDTH-1:0]  nxt_idx
`ifdef DNN_RESULT_TOP2_EN
  ,
  output logic signed [DATA_WIDTH-1:0] nxt_second,
  output logic        [IDX_WIDTH-1:0]  nxt_idx2
`endif
);

  logic signed [DATA_WIDTH-1:0] best;
  logic        [IDX_WIDTH-1:0]  best_idx;

  assign last = (cnt == IDX_WIDTH'(NUM_CLASSES - 1));

`ifdef DNN_RESULT_TOP2_EN
  logic signed [DATA_WIDTH-1:0] second;
  logic        [IDX_WIDTH-1:0]  idx2;

  // second starts at the most negative value with index 1, so element 1 always
  // lands there unless it displaces best; ties keep the lower index
  always_comb begin
    nxt_best   = best;
    nxt_idx    = best_idx;
    nxt_second = second;
    nxt_idx2   = idx2;
    if (elem > best) begin
      nxt_best   = elem;
      nxt_idx    = cnt;
      nxt_second = best;
      nxt_idx2   = best_idx;
    end else if (elem > second) begin
      nxt_second = elem;
      nxt_idx2   = cnt;
    end
  end
`else
  always_comb begin
    nxt_best = best;
    nxt_idx  = best_idx;
    if (elem > best) begin
      nxt_best = elem;
      nxt_idx  = cnt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt      <= '0;
      best     <= '0;
      best_idx <= '0;
`ifdef DNN_RESULT_TOP2_EN
      second   <= '0;
      idx2     <= '0;
`endif
    end else if (start) begin
      cnt      <= IDX_WIDTH'(1);
      best     <= init_val;
      best_idx <= '0;
`ifdef DNN_RESULT_TOP2_EN
      second   <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
      idx2     <= IDX_WIDTH'(1);
`endif
    end else if (step) begin
      cnt      <= cnt + 1'b1;
      best     <= nxt_best;
      best_idx <= nxt_idx;
`ifdef DNN_RESULT_TOP2_EN
      second   <= nxt_second;
      idx2     <= nxt_idx2;
`endif
    end
  end

endmodule

// File: rtl/dnn_result_unit.sv
// rtl/dnn_result_unit.sv - snapshot engine scores, find the winning class, hand it off
// Optional runner-up and margin outputs under DNN_RESULT_TOP2_EN.
module dnn_result_unit
  import dnn_result_pkg::*;
#(
  parameter int  DATA_WIDTH  = DNN_DATA_WIDTH,
  parameter int  NUM_CLASSES = DNN_NUM_CLASSES,
  parameter int  IDX_WIDTH   = idx_width(NUM_CLASSES),
  localparam int RD_WIDTH    = (IDX_WIDTH > 4) ? IDX_WIDTH : 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              eng_done,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] eng_out,
  output logic                              busy,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [IDX_WIDTH-1:0]              res_class,
  output logic [DATA_WIDTH-1:0]             res_score,
  output logic                              overrun,
  input  logic [RD_WIDTH-1:0]               rd_idx,
  output logic [DATA_WIDTH-1:0]             rd_data
`ifdef DNN_RESULT_TOP2_EN
  ,
  output logic [IDX_WIDTH-1:0]              res_class2,
  output logic signed [DATA_WIDTH:0]        res_margin
`endif
);

  state_t                       state;
  logic                         done_d;
  logic                         rise;
  logic signed [DATA_WIDTH-1:0] bank [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] elem;
  logic signed [DATA_WIDTH-1:0] rd_mux;
  logic        [IDX_WIDTH-1:0]  cnt;
  logic                         last;
  logic signed [DATA_WIDTH-1:0] nxt_best;
  logic        [IDX_WIDTH-1:0]  nxt_idx;
`ifdef DNN_RESULT_TOP2_EN
  logic signed [DATA_WIDTH-1:0] nxt_second;
  logic        [IDX_WIDTH-1:0]  nxt_idx2;
`endif

  assign rise = eng_done & ~done_d;

  // explicit mux loops keep out-of-range indices on bank[0]
  always_comb begin
    elem   = bank[0];
    rd_mux = bank[0];
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (cnt == IDX_WIDTH'(i))   elem   = bank[i];
      if (rd_idx == RD_WIDTH'(i)) rd_mux = bank[i];
    end
  end

  dnn_argmax_scan #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CLASSES(NUM_CLASSES),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .start     ((state == IDLE) && rise),
    .step      (state == SCAN),
    .init_val  ($signed(eng_out[DATA_WIDTH-1:0])),
    .elem      (elem),
    .cnt       (cnt),
    .last      (last),
    .nxt_best  (nxt_best),
    .nxt_idx   (nxt_idx)
`ifdef DNN_RESULT_TOP2_EN
    ,
    .nxt_second(nxt_second),
    .nxt_idx2  (nxt_idx2)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      state      <= IDLE;
      done_d     <= 1'b0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_class  <= '0;
      res_score  <= '0;
      overrun    <= 1'b0;
      rd_data    <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) bank[i] <= '0;
`ifdef DNN_RESULT_TOP2_EN
      res_class2 <= '0;
      res_margin <= '0;
`endif
    end else begin
      done_d  <= eng_done;
      rd_data <= rd_mux;
      case (state)
        IDLE: begin
          if (rise) begin
            for (int i = 0; i < NUM_CLASSES; i++)
              bank[i] <= $signed(eng_out[i*DATA_WIDTH +: DATA_WIDTH]);
            busy <= 1'b1;
            if (NUM_CLASSES == 1) begin
              state      <= HOLD;
              res_valid  <= 1'b1;
              res_class  <= '0;
              res_score  <= eng_out[DATA_WIDTH-1:0];
`ifdef DNN_RESULT_TOP2_EN
              res_class2 <= '0;
              res_margin <= '0;
`endif
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (rise) overrun <= 1'b1;
          // results register on the same edge as the final compare
          if (last) begin
            state      <= HOLD;
            res_valid  <= 1'b1;
            res_class  <= nxt_idx;
            res_score  <= nxt_best;
`ifdef DNN_RESULT_TOP2_EN
            res_class2 <= nxt_idx2;
            res_margin <= {nxt_best[DATA_WIDTH-1], nxt_best}
                        - {nxt_second[DATA_WIDTH-1], nxt_second};
`endif
          end
        end
        HOLD: begin
          if (rise) overrun <= 1'b1;
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_result_unit.sv
// tb/tb_dnn_result_unit.sv - randomized self-checking bench with a behavioural readout model
module tb_dnn_result_unit;

  localparam int N  = 10;
  localparam int DW = 12;

  logic              clk = 1'b0;
  logic              rst, clear, eng_done, res_ready;
  logic [N*DW-1:0]   eng_out;
  logic              busy, res_valid, overrun;
  logic [3:0]        res_class;
  logic [DW-1:0]     res_score, rd_data;
  logic [3:0]        rd_idx;
`ifdef DNN_RESULT_TOP2_EN
  logic [3:0]        res_class2;
  logic signed [DW:0] res_margin;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dnn_result_unit dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .eng_done  (eng_done),
    .eng_out   (eng_out),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_class (res_class),
    .res_score (res_score),
    .overrun   (overrun),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data)
`ifdef DNN_RESULT_TOP2_EN
    ,
    .res_class2(res_class2),
    .res_margin(res_margin)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: snapshot, argmax by plain loops, N-1 cycle countdown to valid
  int m_bank[N];
  bit m_busy, m_valid, m_over, m_done_d;
  int m_left, m_class, m_score, m_rd, m_cls2, m_margin;

  always @(posedge clk) begin
    if (!rst || clear) begin
      foreach (m_bank[i]) m_bank[i] = 0;
      m_busy = 0; m_valid = 0; m_over = 0; m_done_d = 0;
      m_left = 0; m_rd = 0;
    end else begin
      bit rise;
      rise = eng_done && !m_done_d;
      m_rd = (rd_idx < N) ? m_bank[rd_idx] : m_bank[0];
      if (!m_busy) begin
        if (rise) begin
          for (int i = 0; i < N; i++) m_bank[i] = int'($signed(eng_out[i*DW +: DW]));
          m_class = 0;
          for (int i = 1; i < N; i++) if (m_bank[i] > m_bank[m_class]) m_class = i;
          m_score = m_bank[m_class];
          m_cls2 = -1;
          for (int i = 0; i < N; i++)
            if (i != m_class && (m_cls2 < 0 || m_bank[i] > m_bank[m_cls2])) m_cls2 = i;
          m_margin = m_score - m_bank[m_cls2];
          m_busy = 1;
          m_left = N - 1;
        end
      end else begin
        if (rise) m_over = 1;
        if (!m_valid) begin
          m_left--;
          if (m_left == 0) m_valid = 1;
        end else if (res_ready) begin
          m_valid = 0;
          m_busy  = 0;
        end
      end
      m_done_d = eng_done;
    end
    #1;
    chk("busy", busy, m_busy);
    chk("res_valid", res_valid, m_valid);
    chk("overrun", overrun, m_over);
    chk("rd_data", int'($signed(rd_data)), m_rd);
    if (m_valid) begin
      chk("res_class", res_class, m_class);
      chk("res_score", int'($signed(res_score)), m_score);
`ifdef DNN_RESULT_TOP2_EN
      chk("res_class2", res_class2, m_cls2);
      chk("res_margin", int'(res_margin), m_margin);
`endif
    end
  end

  int t1[N]   = '{3, -5, 100, 7, 100, 0, -2048, 12, 99, 1};
  int tmin[N] = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
  int ta[N]   = '{0, 0, 0, 0, 0, 50, 0, 0, 0, 0};
  int tb[N]   = '{0, 0, 0, 0, 0, 0, 0, 90, 0, 0};

  task automatic set_scores(input int s[N]);
    for (int i = 0; i < N; i++) eng_out[i*DW +: DW] = DW'(s[i]);
  endtask

  task automatic pulse();
    @(negedge clk); eng_done = 1'b1;
    @(negedge clk); eng_done = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!res_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic accept();
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; clear = 1'b0; eng_done = 1'b0; res_ready = 1'b0;
    eng_out = '0; rd_idx = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_rd", rd_data, 0);
    rst = 1'b1;

    set_scores(t1);
    pulse();
    wait_valid(n);
    chk("latency", n, 9);
    chk("t1_class", res_class, 2);
    chk("t1_score", int'($signed(res_score)), 100);
    repeat (20) @(negedge clk);
    chk("hold_valid", res_valid, 1);
    chk("hold_score", int'($signed(res_score)), 100);
    accept();
    chk("post_ack_valid", res_valid, 0);
    chk("post_ack_busy", busy, 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk); rd_idx = 4'(i);
    end
    @(negedge clk); rd_idx = 4'd2;
    @(negedge clk); chk("rd_idx2", int'($signed(rd_data)), 100);
    rd_idx = 4'd13;
    @(negedge clk); chk("rd_idx13", int'($signed(rd_data)), 3);

    set_scores(tmin);
    pulse();
    wait_valid(n);
    chk("min_class", res_class, 0);
    chk("min_score", int'($signed(res_score)), -2048);
`ifdef DNN_RESULT_TOP2_EN
    chk("min_class2", res_class2, 1);
    chk("min_margin", int'(res_margin), 0);
`endif
    accept();

    set_scores(ta);
    pulse();
    repeat (2) @(negedge clk);
    set_scores(tb);
    pulse();
    wait_valid(n);
    chk("ovr_class", res_class, 5);
    chk("ovr_score", int'($signed(res_score)), 50);
    chk("ovr_flag", overrun, 1);
    accept();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clr_overrun", overrun, 0);
    chk("clr_busy", busy, 0);

    set_scores(t1);
    pulse();
    wait_valid(n);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("rsthold_valid", res_valid, 0);
    chk("rsthold_rd", rd_data, 0);
    chk("rsthold_busy", busy, 0);
    set_scores(tb);
    pulse();
    wait_valid(n);
    chk("recap_class", res_class, 7);
    chk("recap_score", int'($signed(res_score)), 90);
    accept();

    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        int v;
        case ($urandom_range(0, 3))
          0: v = -2048;
          1: v = 2047;
          2: v = $urandom_range(0, 3);
          default: v = $urandom_range(0, 4095) - 2048;
        endcase
        eng_out[i*DW +: DW] = DW'(v);
      end
      if ($urandom_range(0, 5) == 0) eng_done = ~eng_done;
      res_ready = ($urandom_range(0, 3) == 0);
      rd_idx    = 4'($urandom_range(0, 15));
      clear     = ($urandom_range(0, 150) == 0);
      rst       = ($urandom_range(0, 300) != 0);
    end
    @(negedge clk);
    rst = 1'b1; clear = 1'b0; eng_done = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
